alu_shift_pipe: RTL and testbench

Pipelined, parametrised barrel shifter that extends the single-mode combinational logical-right shifter. It supports four modes: logical right, logical left, arithmetic right and rotate right. Shift amounts range from 0 to N, and it uses a valid/ready handshake on both sides. It sits between the ALU operand mux and the ALU result mux, and is used when the full-width combinational shifter does not close timing.

---
 rtl/alu_shift_pkg.sv | 13 +
 rtl/alu_shift_if.sv | 28 ++
 rtl/alu_shift_stage.sv | 30 +++
 rtl/alu_shift_pipe.sv | 84 ++++++++
 tb/tb_alu_shift_pipe.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_shift_pkg.sv
// Shared types for the pipelined barrel shifter.
package alu_shift_pkg;

    typedef enum logic [1:0] {
        OP_SRL = 2'b00,
        OP_SLL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    localparam int unsigned OP_W = 2;

endpackage : alu_shift_pkg

// File: rtl/alu_shift_if.sv
// Operand/result handshake bundle between the operand mux, the shifter and the result mux.
interface alu_shift_if
    import alu_shift_pkg::*;
#(
    parameter int unsigned N  = 32,
    parameter int unsigned SW = $clog2(N) + 1
) ();

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  A;
    logic [SW-1:0] S;
    op_e           op;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  Z;

    modport master (
        output in_valid, A, S, op, out_ready,
        input  in_ready, out_valid, Z
    );

    modport slave (
        input  in_valid, A, S, op, out_ready,
        output in_ready, out_valid, Z
    );

endinterface : alu_shift_if

// File: rtl/alu_shift_stage.sv
// One log-shifter step: shift or rotate by 2**K when en_i is set.
module alu_shift_stage
    import alu_shift_pkg::*;
#(
    parameter int unsigned N = 32,
    parameter int unsigned K = 0
) (
    input  logic [N-1:0] data_i,
    input  op_e          op_i,
    input  logic         en_i,
    input  logic         fill_i,
    output logic [N-1:0] data_o
);

    localparam int unsigned SH = 1 << K;

    // fill_i is already 0 for SRL, so both right shifts share one path
    always_comb begin
        data_o = data_i;
        if (en_i) begin
            case (op_i)
                OP_SRL, OP_SRA: data_o = {{SH{fill_i}}, data_i[N-1:SH]};
                OP_SLL:         data_o = {data_i[N-1-SH:0], {SH{1'b0}}};
                OP_ROR:         data_o = {data_i[SH-1:0], data_i[N-1:SH]};
                default:        data_o = data_i;
            endcase
        end
    end

endmodule : alu_shift_stage

// File: rtl/alu_shift_pipe.sv
// Pipelined four-mode barrel shifter, one register per log stage, global stall.
module alu_shift_pipe
    import alu_shift_pkg::*;
#(
    parameter int unsigned N  = 32,
    parameter int unsigned SW = $clog2(N) + 1
) (
    input  logic        clk,
    input  logic        rst,
    alu_shift_if.slave  bus
);

    localparam int unsigned L = $clog2(N);

    typedef struct packed {
        logic          valid;
        op_e           op;
        logic [SW-1:0] amt;
        logic          fill;
        logic          ovf;
        logic [N-1:0]  data;
    } slot_t;

    slot_t        slot_q  [L];
    slot_t        slot_d  [L];
    slot_t        src     [L];
    logic [N-1:0] shifted [L];
    logic         advance;

    assign advance       = bus.out_ready || !slot_q[L-1].valid;
    assign bus.in_ready  = advance;
    assign bus.out_valid = slot_q[L-1].valid;
    assign bus.Z         = slot_q[L-1].data;

    // Stage inputs: operand bus for stage 0, previous register otherwise
    always_comb begin
        src[0].valid = bus.in_valid;
        src[0].op    = bus.op;
        src[0].amt   = bus.S;
        src[0].fill  = (bus.op == OP_SRA) ? bus.A[N-1] : 1'b0;
        src[0].ovf   = (bus.S >= SW'(N));
        src[0].data  = bus.A;
        for (int k = 1; k < L; k++) begin
            src[k] = slot_q[k-1];
        end
    end

    for (genvar k = 0; k < L; k++) begin : g_stage
        alu_shift_stage #(
            .N (N),
            .K (k)
        ) u_stage (
            .data_i (src[k].data),
            .op_i   (src[k].op),
            .en_i   (src[k].amt[k]),
            .fill_i (src[k].fill),
            .data_o (shifted[k])
        );
    end

    // Out-of-range shifts saturate to the fill pattern on entry to the last register
    always_comb begin
        for (int k = 0; k < L; k++) begin
            slot_d[k]      = src[k];
            slot_d[k].data = shifted[k];
        end
        if (src[L-1].ovf && (src[L-1].op != OP_ROR)) begin
            slot_d[L-1].data = {N{src[L-1].fill}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < L; k++) begin
                slot_q[k] <= '0;
            end
        end else if (advance) begin
            for (int k = 0; k < L; k++) begin
                slot_q[k] <= slot_d[k];
            end
        end
    end

endmodule : alu_shift_pipe

// File: tb/tb_alu_shift_pipe.sv
// Directed and streaming checks for alu_shift_pipe at N=32.
module tb_alu_shift_pipe;
    import alu_shift_pkg::*;

    localparam int unsigned N   = 32;
    localparam int unsigned LAT = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_shift_if #(.N(N)) bus ();

    alu_shift_pipe #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_rx    = 0;
    bit          mon_en  = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_z  = '0;
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [5:0] s, input op_e op);
        int r;
        r = int'(s[4:0]);
        case (op)
            OP_SRL:  return (s >= 6'd32) ? 32'h0 : (a >> s);
            OP_SLL:  return (s >= 6'd32) ? 32'h0 : (a << s);
            OP_SRA:  return (s >= 6'd32) ? {32{a[31]}} : 32'($signed(a) >>> s);
            OP_ROR:  return (a >> r) | (a << (32 - r));
            default: return 32'h0;
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [31:0] a, input logic [5:0] s, input op_e op, output int waits);
        bus.in_valid = 1'b1;
        bus.A        = a;
        bus.S        = s;
        bus.op       = op;
        waits        = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            waits++;
            if (waits > 500) begin
                check("send_timeout", 32'(waits), 32'd0);
                bus.in_valid = 1'b0;
                return;
            end
        end
        exp_q.push_back(model(a, s, op));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Single op into an empty pipe: checks latency and result
    task automatic run_one(input string tag, input logic [31:0] a, input logic [5:0] s,
                           input op_e op, input logic [31:0] exp);
        int w;
        int n;
        send(a, s, op, w);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 20);
        check({tag, "_lat"}, 32'(n), 32'(LAT));
        check(tag, bus.Z, exp);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall) begin
                check("hold_valid", {31'b0, bus.out_valid}, 32'd1);
                check("hold_z", bus.Z, prev_z);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_result", bus.Z, 32'hxxxx_xxxx);
                end else begin
                    n_rx++;
                    check("stream_z", bus.Z, exp_q.pop_front());
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_z     = bus.Z;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  w;
        int  stalls;
        int  any;
        bit  done;
        op_e ops [4];
        ops[0] = OP_SRL; ops[1] = OP_SLL; ops[2] = OP_SRA; ops[3] = OP_ROR;

        // Reset with operands offered: nothing may emerge
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.A         = 32'hDEAD_BEEF;
        bus.S         = 6'd3;
        bus.op        = OP_SLL;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_valid0", {31'b0, bus.out_valid}, 32'd0);
        check("rst_z0", bus.Z, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("rst_valid1", {31'b0, bus.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        any = 0;
        repeat (7) begin
            @(negedge clk);
            if (bus.out_valid) any++;
        end
        check("rst_discard", 32'(any), 32'd0);
        @(posedge clk);
        #1;

        // Mode sweep
        run_one("srl4", 32'h8000_00F1, 6'd4, OP_SRL, 32'h0800_000F);
        run_one("sll4", 32'h8000_00F1, 6'd4, OP_SLL, 32'h0000_0F10);
        run_one("sra4", 32'h8000_00F1, 6'd4, OP_SRA, 32'hF800_000F);
        run_one("ror4", 32'h8000_00F1, 6'd4, OP_ROR, 32'h1800_000F);

        // Boundary amounts
        foreach (ops[i]) run_one("s0", 32'h8000_0001, 6'd0, ops[i], 32'h8000_0001);
        run_one("srl31", 32'h8000_0001, 6'd31, OP_SRL, 32'h0000_0001);
        run_one("sra31", 32'h8000_0001, 6'd31, OP_SRA, 32'hFFFF_FFFF);
        run_one("srl32", 32'h8000_0001, 6'd32, OP_SRL, 32'h0000_0000);
        run_one("sll32", 32'h8000_0001, 6'd32, OP_SLL, 32'h0000_0000);
        run_one("sra32", 32'h8000_0001, 6'd32, OP_SRA, 32'hFFFF_FFFF);
        run_one("ror32", 32'h8000_0001, 6'd32, OP_ROR, 32'h8000_0001);
        run_one("sra40_pos", 32'h7000_0000, 6'd40, OP_SRA, 32'h0000_0000);
        run_one("ror33", 32'h8000_0001, 6'd33, OP_ROR, 32'hC000_0000);

        // Back-to-back stream, no backpressure
        mon_en = 1'b1;
        n_rx   = 0;
        stalls = 0;
        for (int i = 0; i <= 32; i++) begin
            for (int j = 0; j <= 32; j++) begin
                send(32'(i), 6'(j), ops[(i + j) % 4], w);
                stalls += w;
            end
        end
        check("stream_stalls", 32'(stalls), 32'd0);
        drain("stream_drain");
        check("stream_count", 32'(n_rx), 32'd1089);

        // Random backpressure stream
        n_rx = 0;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    send(32'(i * 32'h0101_0F37 + 32'h8000_0000), 6'((i * 7) % 40), ops[i % 4], w);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.out_ready = 1'b1;
        drain("bp_drain");
        check("bp_count", 32'(n_rx), 32'd100);
        mon_en = 1'b0;

        // Reset with three operations in flight
        for (int i = 0; i < 3; i++) send(32'hFFFF_0000 + 32'(i), 6'd1, OP_SRL, w);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        any = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid) any++;
        end
        check("midrst_flush", 32'(any), 32'd0);
        @(posedge clk);
        #1;
        run_one("midrst_next", 32'h0000_00F0, 6'd4, OP_SLL, 32'h0000_0F00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_alu_shift_pipe
